// File: rtl/bundle_mapper_pkg.sv
// Shared types for the bundle stride mapper.
// Contents:
//   state_e     - controller states (idle, operand streaming, kernel wait, result write)
//   mode_e      - request mode: MODE_PAIR bundles hva and hvb, MODE_RANGE bundles hva..hvb at the HV stride
//   log2_stride - exponent of a power-of-two stride, evaluated at elaboration time
package bundle_mapper_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2,
    S_WRITE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_PAIR  = 1'b0,
    MODE_RANGE = 1'b1
  } mode_e;

  // Exponent of a power-of-two stride (1 -> 0, 4 -> 2, ...).
  function automatic int unsigned log2_stride(input int unsigned stride);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((stride >> i) == 32'd1) begin
        r = i;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bundle_stride_mapper_hv_read_fifo.sv
// hv_read_fifo: synchronous skid FIFO holding RAM read returns until the bundle kernel takes them.
// Ports:
//   clk, reset         - clock, synchronous active-high reset (reset empties the FIFO)
//   push, push_data    - write one word (ignored when full and not popping in the same cycle)
//   pop                - remove head word (ignored when empty)
//   head               - current head word (meaningful only while count != 0)
//   count              - number of stored words
module hv_read_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  head,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic                   pop_ok_s;
  logic                   push_ok_s;

  assign pop_ok_s  = pop && (count_r != {COUNT_WIDTH{1'b0}});
  assign push_ok_s = push && ((count_r != COUNT_WIDTH'(DEPTH)) || pop_ok_s);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {COUNT_WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + COUNT_WIDTH'(1);
        2'b01:   count_r <= count_r - COUNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/bundle_stride_mapper.sv
// bundle_stride_mapper: streams N operand HV words per word offset from the HV RAM to the bundle kernel
// and writes each bundled result word back to the destination HV.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   valid, hva, hvb, hvc,
//   word_count, mode                - request (captured in S_IDLE when valid & k_ready)
//   we_n, address, data_wr, data_rd - single RAM port; data_rd returns the cycle after address is presented
//   done, error                     - idle/complete flag, one-cycle reject pulse
//   k_valid, k_first, k_last,
//   k_data_in, k_ready              - operand beat stream to the kernel
//   k_data_out, k_done              - bundled result from the kernel
module bundle_stride_mapper
  import bundle_mapper_pkg::*;
#(
  parameter int HV_DATA_WIDTH          = 32,
  parameter int HV_ADDRESS_WIDTH       = 20,
  parameter int MAX_HYPERVECTOR_LENGTH = 4,
  parameter int READ_FIFO_DEPTH        = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid,
  input  logic [HV_ADDRESS_WIDTH-1:0] hva,
  input  logic [HV_ADDRESS_WIDTH-1:0] hvb,
  input  logic [HV_ADDRESS_WIDTH-1:0] hvc,
  input  logic [HV_ADDRESS_WIDTH-1:0] word_count,
  input  logic                        mode,
  output logic                        we_n,
  output logic [HV_ADDRESS_WIDTH-1:0] address,
  output logic [HV_DATA_WIDTH-1:0]    data_wr,
  input  logic [HV_DATA_WIDTH-1:0]    data_rd,
  output logic                        done,
  output logic                        error,
  output logic                        k_valid,
  output logic                        k_first,
  output logic                        k_last,
  output logic [HV_DATA_WIDTH-1:0]    k_data_in,
  input  logic [HV_DATA_WIDTH-1:0]    k_data_out,
  input  logic                        k_ready,
  input  logic                        k_done
);

  localparam int AW          = HV_ADDRESS_WIDTH;
  localparam int DW          = HV_DATA_WIDTH;
  localparam int CW          = $clog2(READ_FIFO_DEPTH) + 1;
  localparam int STRIDE_LOG2 = int'(log2_stride(MAX_HYPERVECTOR_LENGTH));
  localparam logic [AW-1:0] ZERO_A      = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_A       = AW'(1);
  localparam logic [AW-1:0] TWO_A       = AW'(2);
  localparam logic [AW-1:0] MAX_A       = AW'(MAX_HYPERVECTOR_LENGTH);
  localparam logic [AW-1:0] STRIDE_MASK = AW'(MAX_HYPERVECTOR_LENGTH - 1);

  state_e        state_r, state_s;
  mode_e         mode_r, mode_s;
  logic [AW-1:0] hva_r, hva_s, hvb_r, hvb_s, hvc_r, hvc_s, wc_r, wc_s;
  logic [AW-1:0] n_r, n_s, w_r, w_s, issued_r, issued_s, beat_r, beat_s;
  logic          rd_p1_r, rd_p1_s, rd_p2_r, rd_p2_s;
  logic          we_n_r, we_n_s, done_r, done_s, error_r, error_s;
  logic [AW-1:0] address_r, address_s;
  logic [DW-1:0] data_wr_r, data_wr_s;

  logic [AW-1:0] diff_s, req_n_s, op_base_s, rd_addr_s;
  logic          bad_req_s, issue_ok_s, k_valid_s, fifo_pop_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   occupancy_s;
  logic [DW-1:0] fifo_head_s;

  // rd_p2_r marks the cycle data_rd is valid, so the returned word goes straight into the FIFO.
  hv_read_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (READ_FIFO_DEPTH),
    .COUNT_WIDTH(CW)
  ) u_read_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rd_p2_r),
    .push_data(data_rd),
    .pop      (fifo_pop_s),
    .head     (fifo_head_s),
    .count    (fifo_count_s)
  );

  // Request validation and operand count for the incoming request.
  always_comb begin
    diff_s    = hvb - hva;
    bad_req_s = 1'b0;
    if ((word_count == ZERO_A) || (word_count > MAX_A)) begin
      bad_req_s = 1'b1;
    end else if ((mode_e'(mode) == MODE_RANGE) &&
                 ((hvb < hva) || ((diff_s & STRIDE_MASK) != ZERO_A))) begin
      bad_req_s = 1'b1;
    end else begin
      bad_req_s = 1'b0;
    end
    if (mode_e'(mode) == MODE_RANGE) begin
      req_n_s = (diff_s >> STRIDE_LOG2) + ONE_A;
    end else begin
      req_n_s = TWO_A;
    end
  end

  // Read address of the next operand to fetch at the current word offset.
  always_comb begin
    if (mode_r == MODE_PAIR) begin
      if (issued_r == ZERO_A) begin
        op_base_s = hva_r;
      end else begin
        op_base_s = hvb_r;
      end
    end else begin
      op_base_s = hva_r + (issued_r << STRIDE_LOG2);
    end
    rd_addr_s = op_base_s + w_r;
  end

  // Words already buffered plus words still in the RAM pipeline must never exceed the FIFO depth.
  assign occupancy_s = {1'b0, fifo_count_s} + (CW + 1)'(rd_p1_r) + (CW + 1)'(rd_p2_r);
  assign issue_ok_s  = (state_r == S_STREAM) && (issued_r < n_r) &&
                       (occupancy_s < (CW + 1)'(READ_FIFO_DEPTH));
  assign k_valid_s   = (state_r == S_STREAM) && (fifo_count_s != {CW{1'b0}});

  // Next-state and next-output computation.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    hva_s      = hva_r;
    hvb_s      = hvb_r;
    hvc_s      = hvc_r;
    wc_s       = wc_r;
    n_s        = n_r;
    w_s        = w_r;
    issued_s   = issued_r;
    beat_s     = beat_r;
    rd_p1_s    = 1'b0;
    rd_p2_s    = rd_p1_r;
    we_n_s     = 1'b1;
    address_s  = address_r;
    data_wr_s  = data_wr_r;
    done_s     = done_r;
    error_s    = 1'b0;
    fifo_pop_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (valid && k_ready) begin
          if (bad_req_s) begin
            error_s = 1'b1;
          end else begin
            hva_s    = hva;
            hvb_s    = hvb;
            hvc_s    = hvc;
            wc_s     = word_count;
            mode_s   = mode_e'(mode);
            n_s      = req_n_s;
            w_s      = ZERO_A;
            issued_s = ZERO_A;
            beat_s   = ZERO_A;
            done_s   = 1'b0;
            state_s  = S_STREAM;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_STREAM: begin
        if (issue_ok_s) begin
          address_s = rd_addr_s;
          issued_s  = issued_r + ONE_A;
          rd_p1_s   = 1'b1;
        end else begin
          rd_p1_s = 1'b0;
        end
        if (k_valid_s && k_ready) begin
          fifo_pop_s = 1'b1;
          if (beat_r == (n_r - ONE_A)) begin
            beat_s  = ZERO_A;
            state_s = S_WAIT;
          end else begin
            beat_s = beat_r + ONE_A;
          end
        end else begin
          fifo_pop_s = 1'b0;
        end
      end
      S_WAIT: begin
        if (k_done) begin
          address_s = hvc_r + w_r;
          data_wr_s = k_data_out;
          we_n_s    = 1'b0;
          state_s   = S_WRITE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WRITE: begin
        if ((w_r + ONE_A) < wc_r) begin
          w_s      = w_r + ONE_A;
          issued_s = ZERO_A;
          state_s  = S_STREAM;
        end else begin
          done_s  = 1'b1;
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, request context and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      mode_r    <= MODE_PAIR;
      hva_r     <= ZERO_A;
      hvb_r     <= ZERO_A;
      hvc_r     <= ZERO_A;
      wc_r      <= ZERO_A;
      n_r       <= ZERO_A;
      w_r       <= ZERO_A;
      issued_r  <= ZERO_A;
      beat_r    <= ZERO_A;
      rd_p1_r   <= 1'b0;
      rd_p2_r   <= 1'b0;
      we_n_r    <= 1'b1;
      address_r <= {AW{1'b1}};
      data_wr_r <= {DW{1'b0}};
      done_r    <= 1'b1;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      mode_r    <= mode_s;
      hva_r     <= hva_s;
      hvb_r     <= hvb_s;
      hvc_r     <= hvc_s;
      wc_r      <= wc_s;
      n_r       <= n_s;
      w_r       <= w_s;
      issued_r  <= issued_s;
      beat_r    <= beat_s;
      rd_p1_r   <= rd_p1_s;
      rd_p2_r   <= rd_p2_s;
      we_n_r    <= we_n_s;
      address_r <= address_s;
      data_wr_r <= data_wr_s;
      done_r    <= done_s;
      error_r   <= error_s;
    end
  end

  assign we_n      = we_n_r;
  assign address   = address_r;
  assign data_wr   = data_wr_r;
  assign done      = done_r;
  assign error     = error_r;
  assign k_valid   = k_valid_s;
  assign k_first   = k_valid_s && (beat_r == ZERO_A);
  assign k_last    = k_valid_s && (beat_r == (n_r - ONE_A));
  assign k_data_in = fifo_head_s;

endmodule
